// File: rtl/xor_serial_mux_unit.sv
// Bit-serial XOR/XNOR of two WIDTH-bit operands built from 2:1 mux cells.
// Produces BITS_PER_CYCLE result bits per clock plus running parity.
module xor_serial_mux_unit #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             parity
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH < 1) || (WIDTH % BITS_PER_CYCLE != 0)) begin : g_bad_param
    $error("xor_serial_mux_unit: BITS_PER_CYCLE must divide WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0]             cnt;
  logic [WIDTH-1:0]          a_q;
  logic [WIDTH-1:0]          b_q;
  logic                      mode_q;
  logic [WIDTH-1:0]          o_q;
  logic                      par_q;
  logic [BITS_PER_CYCLE-1:0] slice;
  logic                      accept;
  logic                      last;

  function automatic logic mux2(
    input logic sel,
    input logic d0,
    input logic d1
  );
    return sel ? d1 : d0;
  endfunction

  // Operands shift right each RUN cycle, so bit j of the slice is always a_q[j].
  for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_bit
    logic na;
    logic r;
    logic nr;
    assign na       = mux2(a_q[j], 1'b1, 1'b0);
    assign r        = mux2(b_q[j], a_q[j], na);
    assign nr       = mux2(r, 1'b1, 1'b0);
    assign slice[j] = mux2(mode_q, r, nr);
  end

  assign accept = (state == IDLE) && in_valid;
  assign last   = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      o_q    <= '0;
      par_q  <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: begin
          cnt    <= '0;
          a_q    <= a;
          b_q    <= b;
          mode_q <= mode;
          o_q    <= '0;
          par_q  <= 1'b0;
        end
        (state == RUN): begin
          o_q[int'(cnt)*BITS_PER_CYCLE +: BITS_PER_CYCLE] <= slice;
          par_q <= par_q ^ (^slice);
          a_q   <= a_q >> BITS_PER_CYCLE;
          b_q   <= b_q >> BITS_PER_CYCLE;
          if (!last) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign o      = o_q;
  assign parity = par_q;

endmodule

// File: doc/xor_serial_mux_unit.md
Name: xor_serial_mux_unit

Overview:
- Parametrised, bit-serial successor of the single-bit mux-built XOR gate.
- Accepts two WIDTH-bit operands over a valid/ready handshake.
- Computes their bitwise XOR or XNOR, BITS_PER_CYCLE bits per clock, using only 2:1 mux cells plus constants.
- Returns the WIDTH-bit result and its reduction parity over a second valid/ready handshake.
- Sits between operand producers and checksum/parity consumers in the combinational-logic exercise chain.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 1.
- BITS_PER_CYCLE, 1, result bits produced per clock; must divide WIDTH exactly.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- mode  input  1  0 = XOR, 1 = XNOR; sampled at accept.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- o  output  WIDTH  result.
- parity  output  1  XOR-reduction of o.

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-low (rst_n), polarity and synchronicity fixed.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0, o = 0, parity = 0, slice counter = 0.
  - Reset has priority over every other event, including mid-RUN and mid-DONE; any in-flight operation is discarded.
- States: IDLE, RUN, DONE. N = WIDTH / BITS_PER_CYCLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a, b and mode; clear the result register and parity accumulator; set counter = 0; go to RUN.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each cycle, result slice [cnt*BITS_PER_CYCLE +: BITS_PER_CYCLE] is written.
  - Per-bit function is built from 2:1 muxes only:
    - r = b ? ~a : a, where ~a is itself a mux with constant inputs (d0 = 1, d1 = 0, sel = a).
    - XNOR is a further mux stage with sel = latched mode.
  - The parity accumulator XORs in every new slice bit.
  - At cnt == N-1, write the last slice, then go to DONE. Otherwise cnt increments.
- DONE:
  - out_valid = 1; o and parity are held stable until the handshake.
  - On out_ready, go to IDLE (out_valid drops next cycle). o and parity keep their last value after leaving DONE.
- Latency: acceptance edge T → out_valid high from edge T+N. A consumer holding out_ready = 1 completes the handshake on edge T+N+1.
- Throughput: one operation per N+2 cycles at best. There is no overlap; in_ready is low throughout RUN and DONE.
- Handshake rules:
  - in_valid asserted while in_ready = 0 is ignored, not queued.
  - a, b and mode changing during RUN has no effect.
  - out_ready while out_valid = 0 is ignored.
  - No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Boundary cases:
  - WIDTH == BITS_PER_CYCLE: N = 1, so RUN lasts exactly one cycle.
  - WIDTH = 1 is legal.
  - The counter is $clog2(N)-wide (minimum 1 bit) and never wraps past N-1.
- Illegal parameter combination (WIDTH % BITS_PER_CYCLE != 0): elaboration-time $error.

Test Plan:
- WIDTH = 8, BITS_PER_CYCLE = 1, a = 8'hA5, b = 8'h3C, mode = 0, out_ready = 1 → out_valid rises exactly 8 cycles after accept; o = 8'h99, parity = 0.
- Same operands, mode = 1 → o = 8'h66, parity = 0. Then a = 8'h07, b = 8'h00, mode = 0 → o = 8'h07, parity = 1.
- WIDTH = 8, BITS_PER_CYCLE = 4, a = 8'hF0, b = 8'hFF, mode = 0 → o = 8'h0F, parity = 0, out_valid 2 cycles after accept.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE → out_valid, o and parity stay constant. A new in_valid with a = 8'h11 during DONE is not accepted (in_ready = 0). Raise out_ready → the block returns to IDLE, then accepts a = 8'h11.
- Drive rst_n = 0 for 1 cycle at RUN cycle 3 → next cycle state = IDLE, in_ready = 1, out_valid = 0, o = 0, parity = 0. A following op a = 8'hFF, b = 8'h00 yields o = 8'hFF, parity = 0.
- Exhaustive WIDTH = 2, BITS_PER_CYCLE = 1: all 16 (a, b) pairs × both modes → o matches a^b or ~(a^b), and parity = ^o, for all 32 operations.
